// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// state encoding, slice width and the operand-width legality rule.
package nibble_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Operand width must split into whole nibbles, with at least two of them.
  function automatic bit width_legal(input int w);
    return ((w % NIBBLE_W) == 0) && (w >= 2 * NIBBLE_W);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_cla.sv
// Combinational 4-bit carry-lookahead adder slice with group propagate/generate.
module nibble_cla_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign p = &prop;
  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);

  assign s    = prop ^ c;
  assign cout = g | (p & cin);

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract computed one nibble per clock, LSB first, through a
// single shared 4-bit CLA slice; publishes sum with carry/overflow/zero flags.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = $clog2(NIB);

  if (!width_legal(WIDTH)) begin : g_width_check
    $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
  end

  function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   part;
  logic [WIDTH-1:0]   part_nxt;
  logic [3:0]         slice_s;
  logic               slice_co;
  logic               slice_p_unused;
  logic               slice_g_unused;
  logic               last;

  assign last = (idx == IDX_W'(NIB - 1));

  nibble_cla_add u_slice (
    .a    (opa[NIBBLE_W*idx +: NIBBLE_W]),
    .b    (opb[NIBBLE_W*idx +: NIBBLE_W]),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_co),
    .p    (slice_p_unused),
    .g    (slice_g_unused)
  );

  // Partial result with the current nibble merged in; on the last nibble this
  // is the complete sum.
  always_comb begin
    part_nxt = part;
    part_nxt[NIBBLE_W*idx +: NIBBLE_W] = slice_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Carry register is reloaded from sub on every accept, giving the +1 of
  // two's-complement negation and preventing carry leakage between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa   <= '0;
      opb   <= '0;
      part  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          part  <= part_nxt;
          carry <= slice_co;
          if (last) begin
            sum  <= part_nxt;
            cout <= slice_co;
            ovf  <= ovf_flag(opa[WIDTH-1], opb[WIDTH-1], part_nxt[WIDTH-1]);
            zero <= (part_nxt == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub at WIDTH=16.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Accept one operation, then count edges until done (bounded).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tsub, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat,
                               input logic [15:0] es, input logic ec,
                               input logic eo, input logic ez);
    chk({tag, "_lat"},  lat, 4);
    chk({tag, "_sum"},  sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"},  ovf, eo);
    chk({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_flags", {busy, done, cout, ovf, zero}, 5'b0);
    chk("rst_sum", sum, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // 1: plain add, also check busy on the cycle after accept
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t1_busy_first", {busy, done}, 2'b10);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done) chk("t1_stable_sum", sum, 16'h0000);
    end
    expect_result("t1", lat, 16'h2345, 1'b0, 1'b0, 1'b0);

    // 2: full ripple to zero
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    expect_result("t2", lat, 16'h0000, 1'b1, 1'b0, 1'b1);

    // 3: signed overflow on add and subtract
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    expect_result("t3a", lat, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    expect_result("t3b", lat, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // 4: borrow, then back-to-back at the earliest accept edge
    run_op(16'h0005, 16'h0007, 1'b1, lat);
    expect_result("t4a", lat, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h0003, 16'h0003, 1'b0, lat);
    expect_result("t4b", lat, 16'h0006, 1'b0, 1'b0, 1'b0);

    // 5: start held high through RUN and DONE with different operands
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t5_lat", lat, 4);
    chk("t5_sum", sum, 16'h0002);
    @(posedge clk); #1;
    chk("t5_idle", {busy, done}, 2'b00);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_no_second", {busy, done}, 2'b00);
    end
    chk("t5_sum_hold", sum, 16'h0002);

    // 6: asynchronous reset mid-RUN, then normal operation
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_async_ctl", {busy, done, cout, ovf, zero}, 5'b0);
    chk("t6_async_sum", sum, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    expect_result("t6", lat, 16'h0100, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Multi-cycle sequencer that performs a WIDTH-bit add or subtract using a single 4-bit carry-lookahead adder slice.
It processes one nibble per clock, LSB first, and keeps the inter-nibble carry in a register.
Results are published together with carry, signed-overflow and zero flags.
It sits between a requester with a start/done handshake and the shared 4-bit adder datapath, as the low-area alternative to a full-width CLA tree.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).
NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only when busy=0.
sub  input  1  0 = a+b, 1 = a-b; sampled with start.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
busy  output  1  high from the cycle after start is accepted until done drops.
done  output  1  one-cycle pulse; result outputs are updated in this cycle.
sum  output  WIDTH  result; holds its value until the next done.
cout  output  1  carry out of bit WIDTH-1; for sub, 1 = no borrow.
ovf  output  1  two's-complement overflow of the operation.
zero  output  1  high when sum == 0.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-RUN):
  - state=IDLE, nibble counter=0, carry register=0.
  - Operand and partial-result registers are cleared.
  - busy, done, sum, cout, ovf and zero are all 0.
- FSM states: IDLE, RUN, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - When start=1 at an edge: latch a into opA, (sub ? ~b : b) into opB, and sub into the carry register (this forms the +1 of two's complement). Clear idx, go to RUN.
  - When start=0: stay in IDLE.
- RUN, at each edge with index idx:
  - The slice adds opA[4*idx+3:4*idx] + opB nibble + carry register.
  - The 4-bit sum is written into partial-result nibble idx.
  - The slice carry-out is written into the carry register.
  - idx increments.
  - On the edge where idx == NIB-1, go to DONE and load the output registers: sum = full partial result including the final nibble, cout = final slice carry-out.
- Flags (computed from registered values):
  - ovf = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]), where opB is the possibly inverted operand.
  - zero = (sum == 0).
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- Latency, with start accepted at edge E0:
  - RUN covers E0..E(NIB-1), so done is high in the cycle following edge E(NIB).
  - busy is high for NIB+1 cycles.
  - The earliest next accept is edge E(NIB+2).
- start while busy=1 (RUN or DONE) is ignored, and a/b/sub changes have no effect. No queueing.
- sum/cout/ovf/zero change only on entry to DONE or on reset; they are stable during RUN.
- Carry never leaks between operations: the carry register is reloaded from sub on every accept.
- The nibble counter is ceil(log2(NIB)) bits wide. It does not wrap in normal flow because it is cleared on accept.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4, and the WIDTH%4 legality check.
- One sub-module: nibble_cla_add. It is the combinational 4-bit carry-lookahead slice with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout, group P, group G.
- Instantiate it once. Group P/G are left unused by this block.

Test Plan:
1. WIDTH=16, reset then start a=0x1234 b=0x1111 sub=0 -> busy for 5 cycles; done in the 5th cycle; sum=0x2345, cout=0, ovf=0, zero=0.
2. a=0xFFFF b=0x0001 sub=0 -> sum=0x0000, cout=1, zero=1, ovf=0; carry ripples across all 4 nibbles.
3. a=0x7FFF b=0x0001 sub=0 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF, ovf=1, cout=1.
4. a=0x0005 b=0x0007 sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then back-to-back a=0x0003 b=0x0003 sub=0 accepted at the earliest legal edge -> sum=0x0006, cout=0 (no carry leakage from the previous operation).
5. start pulsed every cycle during RUN and DONE with a=0xAAAA b=0x5555 after an accepted 0x0001+0x0001 -> single done; sum=0x0002; no second operation until start is reasserted in IDLE.
6. Assert reset asynchronously (between edges) after 2 RUN nibbles -> busy/done/sum/flags go to 0 without a clock edge. After release, start 0x00FF+0x0001 -> sum=0x0100, cout=0, normal latency.
